perf_counter_ctrl: RTL
======================

PERF_COUNTER_CTRL -- requirements
Module: perf_counter_ctrl

Interface
REQ-001 Parameter NUM_CNT, default 7, number of counters sequenced for readout (legal 2..8).
REQ-002 Parameter CNT_W, default 32, counter and window width.
REQ-003 Ports: clk  in  1  sole clock, all logic on rising edge.
REQ-004 Ports: rst  in  1  synchronous, active-high reset.
REQ-005 Ports: cmd_valid in 1 / cmd_ready out 1, command handshake; transfer when both high on a rising edge.
REQ-006 Ports: cmd_op in 3 (0 NOP, 1 START, 2 STOP, 3 CLEAR, 4 DUMP, 5 SET_WINDOW, 6-7 treated as NOP); cmd_data in CNT_W, window length for SET_WINDOW.
REQ-007 Ports: count_en out 1, gates all event strobes feeding the counter bank; counter_clear out 1, one-cycle clear pulse to the counter bank.
REQ-008 Ports: cnt_sel out 3, counter index to the external read mux; cnt_data in CNT_W, mux output, valid same cycle.
REQ-009 Ports: rd_valid out 1 / rd_ready in 1, rd_data out CNT_W, rd_idx out 3, rd_last out 1, readout stream.
REQ-010 Ports: running out 1 (state RUN), window_done out 1 (one-cycle pulse on auto-stop).

Function
REQ-011 FSM states IDLE, RUN, DUMP; DUMP records return state (IDLE or RUN).
REQ-012 count_en high only in RUN; low in IDLE and DUMP, so dumped values form a coherent snapshot.
REQ-013 cmd_ready high in IDLE and RUN, low in DUMP.
REQ-014 START: IDLE->RUN next cycle; in RUN no effect.
REQ-015 STOP: RUN->IDLE next cycle; in IDLE no effect.
REQ-016 CLEAR: counter_clear high exactly the next cycle; state and window unchanged.
REQ-017 DUMP: accepted at edge T -> state DUMP with cnt_sel=0 during cycle T+1; first rd_valid during T+2 with rd_idx=0.
REQ-018 In DUMP, output register loads {cnt_data, cnt_sel} when empty or when rd_valid&&rd_ready, then cnt_sel increments; sustained 1 word/cycle with rd_ready held high.
REQ-019 rd_data, rd_idx, rd_last stable while rd_valid&&!rd_ready; rd_last high only with rd_idx=NUM_CNT-1.
REQ-020 Transfer of rd_last word returns FSM to recorded state next cycle; rd_valid low that cycle.
REQ-021 Exactly NUM_CNT words per DUMP, indices 0..NUM_CNT-1 ascending, no gaps or repeats.
REQ-022 SET_WINDOW loads cmd_data into window register in any accepting state; 0 means unlimited.
REQ-023 On RUN entry, window counter loads window register; decrements each RUN cycle; RUN->IDLE with window_done pulse on the cycle it reaches 0 from 1 (window=N gives exactly N count_en cycles).
REQ-024 Window counter frozen during DUMP; resumes on return to RUN.
REQ-025 STOP accepted same cycle as window expiry: go IDLE, window_done not pulsed.

Reset
REQ-026 rst forces IDLE, cnt_sel=0, window register 0, window counter 0, return state IDLE.
REQ-027 During rst and first cycle after: count_en, counter_clear, rd_valid, rd_last, running, window_done low; rd_data, rd_idx 0; cmd_ready high first cycle after rst.
REQ-028 rst mid-DUMP aborts readout; partial stream not resumed.

Configuration
REQ-029 Macro PERF_CTRL_WINDOW_EN defined: REQ-022..025 implemented.
REQ-030 Macro undefined: no window logic; SET_WINDOW accepted as NOP; window_done tied low; RUN ends only by STOP.

Structure
REQ-031 Package perf_ctrl_pkg holds cmd_op encodings, FSM state type, default NUM_CNT/CNT_W constants.
REQ-032 Sub-module perf_ctrl_window_timer holds window register and down-counter, instantiated only under PERF_CTRL_WINDOW_EN.

Verification
REQ-033 START, 10 cycles, STOP -> count_en high exactly 10 cycles, running matches.
REQ-034 SET_WINDOW 5, START -> count_en high 5 cycles, window_done single pulse, state IDLE.
REQ-035 DUMP from RUN with rd_ready=1, cnt_data=0x100+cnt_sel -> 7 words 0x100..0x106, rd_last on idx 6, count_en low throughout, RUN resumed.
REQ-036 DUMP with rd_ready toggling 1/0 -> rd_data held while stalled, no word lost or duplicated.
REQ-037 CLEAR during RUN -> one counter_clear pulse, running stays high; rst at 3rd dump word -> rd_valid low, IDLE.
REQ-038 Window 3 and STOP same cycle as expiry -> IDLE, no window_done; macro off -> SET_WINDOW ignored.

Source files
------------

// File: rtl/perf_ctrl_pkg.sv
// Shared command encodings, FSM state type and default sizing for perf_counter_ctrl.
package perf_ctrl_pkg;

   localparam int unsigned DEF_NUM_CNT = 7;
   localparam int unsigned DEF_CNT_W   = 32;

   typedef enum logic [2:0] {
      OP_NOP        = 3'd0,
      OP_START      = 3'd1,
      OP_STOP       = 3'd2,
      OP_CLEAR      = 3'd3,
      OP_DUMP       = 3'd4,
      OP_SET_WINDOW = 3'd5
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DUMP
   } state_e;

endpackage

// File: rtl/perf_ctrl_window_timer.sv
// Measurement window: programmable length register plus RUN-cycle down-counter.
// Only instantiated when PERF_CTRL_WINDOW_EN is defined.
module perf_ctrl_window_timer
   import perf_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             set_i,
   input  logic [CNT_W-1:0] set_val_i,
   input  logic             load_i,
   input  logic             tick_i,
   output logic             expire_o
);

   logic [CNT_W-1:0] win_q, win_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      win_d = win_q;
      cnt_d = cnt_q;
      if (set_i) begin
         win_d = set_val_i;
      end
      // A zero count never decrements, so window length 0 runs unlimited.
      if (load_i) begin
         cnt_d = win_q;
      end else if (tick_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         win_q <= '0;
         cnt_q <= '0;
      end else begin
         win_q <= win_d;
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = tick_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/perf_counter_ctrl.sv
// Performance counter bank controller: run gating, clear pulse and snapshot readout stream.
// Define PERF_CTRL_WINDOW_EN to enable the auto-stop measurement window.
module perf_counter_ctrl
   import perf_ctrl_pkg::*;
#(
   parameter int unsigned NUM_CNT = DEF_NUM_CNT,
   parameter int unsigned CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_data,
   output logic             count_en,
   output logic             counter_clear,
   output logic [2:0]       cnt_sel,
   input  logic [CNT_W-1:0] cnt_data,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [CNT_W-1:0] rd_data,
   output logic [2:0]       rd_idx,
   output logic             rd_last,
   output logic             running,
   output logic             window_done
);

   localparam logic [2:0] LAST_SEL = 3'(NUM_CNT - 1);

   state_e           state_q, state_d;
   state_e           ret_q, ret_d;
   state_e           run_next;
   logic [2:0]       sel_q, sel_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] data_q, data_d;
   logic             vld_q, vld_d;
   logic             last_q, last_d;
   logic             issued_q, issued_d;
   logic             clr_q, clr_d;
   logic             done_q, done_d;
   logic             cmd_fire;
   logic             win_expire;

   assign cmd_ready = (state_q != ST_DUMP);
   assign cmd_fire  = cmd_valid && cmd_ready;

`ifdef PERF_CTRL_WINDOW_EN
   logic win_set;
   logic win_load;

   assign win_set  = cmd_fire && (cmd_op == OP_SET_WINDOW);
   assign win_load = cmd_fire && (state_q == ST_IDLE) && (cmd_op == OP_START);

   perf_ctrl_window_timer #(
      .CNT_W (CNT_W)
   ) u_window_timer (
      .clk_i     (clk),
      .rst_i     (rst),
      .set_i     (win_set),
      .set_val_i (cmd_data),
      .load_i    (win_load),
      .tick_i    (state_q == ST_RUN),
      .expire_o  (win_expire)
   );
`else
   logic unused_cmd_data;

   assign unused_cmd_data = ^cmd_data;
   assign win_expire      = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      ret_d    = ret_q;
      sel_d    = sel_q;
      idx_d    = idx_q;
      data_d   = data_q;
      vld_d    = vld_q;
      last_d   = last_q;
      issued_d = issued_q;
      clr_d    = 1'b0;
      done_d   = 1'b0;
      run_next = win_expire ? ST_IDLE : ST_RUN;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               case (cmd_op)
                  OP_START: state_d = ST_RUN;
                  OP_CLEAR: clr_d   = 1'b1;
                  OP_DUMP: begin
                     state_d  = ST_DUMP;
                     ret_d    = ST_IDLE;
                     sel_d    = '0;
                     issued_d = 1'b0;
                  end
                  default: ;
               endcase
            end
         end

         ST_RUN: begin
            state_d = run_next;
            done_d  = win_expire;
            // STOP on the expiry cycle wins and suppresses window_done; a DUMP
            // then returns to wherever the window would have taken us.
            if (cmd_fire) begin
               case (cmd_op)
                  OP_STOP: begin
                     state_d = ST_IDLE;
                     done_d  = 1'b0;
                  end
                  OP_CLEAR: clr_d = 1'b1;
                  OP_DUMP: begin
                     state_d  = ST_DUMP;
                     ret_d    = run_next;
                     sel_d    = '0;
                     issued_d = 1'b0;
                  end
                  default: ;
               endcase
            end
         end

         ST_DUMP: begin
            if (vld_q && rd_ready && last_q) begin
               state_d = ret_q;
               vld_d   = 1'b0;
               last_d  = 1'b0;
            end else if (!vld_q || rd_ready) begin
               if (!issued_q) begin
                  vld_d  = 1'b1;
                  data_d = cnt_data;
                  idx_d  = sel_q;
                  last_d = (sel_q == LAST_SEL);
                  if (sel_q == LAST_SEL) begin
                     issued_d = 1'b1;
                     sel_d    = '0;
                  end else begin
                     sel_d = sel_q + 3'd1;
                  end
               end else begin
                  vld_d  = 1'b0;
                  last_d = 1'b0;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         ret_q    <= ST_IDLE;
         sel_q    <= '0;
         idx_q    <= '0;
         data_q   <= '0;
         vld_q    <= 1'b0;
         last_q   <= 1'b0;
         issued_q <= 1'b0;
         clr_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ret_q    <= ret_d;
         sel_q    <= sel_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         vld_q    <= vld_d;
         last_q   <= last_d;
         issued_q <= issued_d;
         clr_q    <= clr_d;
         done_q   <= done_d;
      end
   end

   assign count_en      = (state_q == ST_RUN);
   assign running       = (state_q == ST_RUN);
   assign counter_clear = clr_q;
   assign window_done   = done_q;
   assign cnt_sel       = sel_q;
   assign rd_valid      = vld_q;
   assign rd_data       = data_q;
   assign rd_idx        = idx_q;
   assign rd_last       = last_q;

endmodule
